// File: rtl/cosim_pkg.sv
// Shared cosim retirement types and constants.
// Holds the change-op and record layouts plus a lane popcount helper.
package cosim_pkg;

    localparam int CS_RTL_MAX_NRET = 4;
    localparam int CS_XLEN         = 64;
    localparam int CS_MAX_OP       = 4;
    localparam int CS_OPNW         = $clog2(CS_MAX_OP + 1);

    // access holds the csChgAccess_t ordinal
    typedef struct packed {
        logic [7:0]         access;
        logic [CS_XLEN-1:0] addr;
        logic [CS_XLEN-1:0] data;
    } cs_rtl_op_t;

    typedef struct packed {
        logic [63:0]         seq;
        logic [CS_XLEN-1:0]  pc;
        logic [31:0]         ir;
        logic [CS_OPNW-1:0]  op_num;
        cs_rtl_op_t [CS_MAX_OP-1:0] ops;
    } cs_rtl_rec_t;

    function automatic int cs_lane_count(
        input logic [CS_RTL_MAX_NRET-1:0] v
    );
        int n;
        n = 0;
        for (int i = 0; i < CS_RTL_MAX_NRET; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/cosim_mwsr_fifo.sv
// Multi-write single-read record storage with wrap-bit pointers.
// Ports: i_wr_en/i_wr_cnt/i_wr_data (lanes 0..cnt-1), i_rd_en, o_rd_valid/o_rd_data, o_count.
module cosim_mwsr_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int NW    = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(NW + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    input  logic            i_wr_en,
    input  logic [CW-1:0]   i_wr_cnt,
    input  logic [NW*W-1:0] i_wr_data,
    input  logic            i_rd_en,
    output logic            o_rd_valid,
    output logic [W-1:0]    o_rd_data,
    output logic [AW:0]     o_count
);

    localparam logic [AW:0] L_FULL = (AW + 1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_empty;
    logic          w_full;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];
    assign w_empty  = (r_wr_ptr[AW] == r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
    assign o_count  = w_full ? L_FULL : {1'b0, w_wr_idx - w_rd_idx};

    // Empty slots read as zero so idle output data is clean
    assign o_rd_valid = !w_empty;
    assign o_rd_data  = w_empty ? '0 : r_mem[w_rd_idx];

    always_ff @(posedge clk) begin
        if (i_wr_en && !i_flush) begin
            for (int i = 0; i < NW; i++) begin
                if (i < int'(i_wr_cnt)) begin
                    r_mem[w_wr_idx + AW'(i)] <= i_wr_data[i*W +: W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + (AW + 1)'(i_wr_cnt);
            end
            if (i_rd_en && !w_empty) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cosim_retire_buffer.sv
// Collects NRET-lane retirement records and hands them to the cosim checker in order.
// Ports: ret_* commit lanes in, ret_stall out; out_* head record with valid/ready; occupancy, sticky err_*.
module cosim_retire_buffer
    import cosim_pkg::*;
#(
    parameter int NRET   = 2,
    parameter int XLEN   = 64,
    parameter int MAX_OP = 4,
    parameter int DEPTH  = 16,
    localparam int OPNW  = $clog2(MAX_OP + 1),
    localparam int OPW   = 8 + 2 * XLEN,
    localparam int OCW   = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NRET-1:0]          ret_valid,
    input  logic [NRET*XLEN-1:0]     ret_pc,
    input  logic [NRET*32-1:0]       ret_ir,
    input  logic [NRET*OPNW-1:0]     ret_op_num,
    input  logic [NRET*MAX_OP*OPW-1:0] ret_ops,
    output logic                     ret_stall,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_seq,
    output logic [XLEN-1:0]          out_pc,
    output logic [31:0]              out_ir,
    output logic [OPNW-1:0]          out_op_num,
    output logic [MAX_OP*OPW-1:0]    out_ops,
    output logic [OCW-1:0]           occupancy,
    output logic                     err_ovf,
    output logic                     err_proto
);

    localparam int OPSW = MAX_OP * OPW;
    localparam int RECW = 64 + XLEN + 32 + OPNW + OPSW;
    localparam int CNTW = $clog2(NRET + 1);

    logic [63:0]        r_seq;
    logic               r_stall;
    logic               r_err_ovf;
    logic               r_err_proto;

    logic [CNTW-1:0]    w_cnt;
    logic [NRET-1:0]    w_mask;
    logic               w_contig;
    logic               w_opbad;
    logic               w_pop;
    logic               w_push;
    logic               w_ovf;
    int                 w_free;
    int                 w_occ_next;
    logic [OPNW-1:0]    w_num;
    logic [OPSW-1:0]    w_ops;
    logic [NRET*RECW-1:0] w_wdata;
    logic               w_rd_valid;
    logic [RECW-1:0]    w_rd_data;
    logic [OCW-1:0]     w_count;

    // Lane records: seq tag, op_num clamp, unused op slots zeroed
    always_comb begin
        w_cnt   = CNTW'(cs_lane_count(CS_RTL_MAX_NRET'(ret_valid)));
        w_mask  = '0;
        w_opbad = 1'b0;
        w_num   = '0;
        w_ops   = '0;
        w_wdata = '0;
        for (int i = 0; i < NRET; i++) begin
            w_mask[i] = (i < int'(w_cnt));
            w_num = ret_op_num[i*OPNW +: OPNW];
            if (ret_valid[i] && int'(w_num) > MAX_OP) begin
                w_opbad = 1'b1;
                w_num   = OPNW'(MAX_OP);
            end
            w_ops = ret_ops[i*OPSW +: OPSW];
            for (int k = 0; k < MAX_OP; k++) begin
                if (k >= int'(w_num)) begin
                    w_ops[k*OPW +: OPW] = '0;
                end
            end
            w_wdata[i*RECW +: RECW] = {r_seq + 64'(i),
                                       ret_pc[i*XLEN +: XLEN],
                                       ret_ir[i*32 +: 32],
                                       w_num, w_ops};
        end
    end

    // Group-level accept decision; a group is never partially written
    always_comb begin
        w_contig   = (ret_valid == w_mask);
        w_pop      = w_rd_valid && out_ready;
        w_free     = DEPTH - int'(w_count) + int'(w_pop);
        w_ovf      = w_contig && (int'(w_cnt) > w_free);
        w_push     = w_contig && !w_ovf && !flush && (w_cnt != '0);
        w_occ_next = flush ? 0
                   : int'(w_count) + (w_push ? int'(w_cnt) : 0) - int'(w_pop);
    end

    cosim_mwsr_fifo #(
        .W     (RECW),
        .DEPTH (DEPTH),
        .NW    (NRET)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (flush),
        .i_wr_en    (w_push),
        .i_wr_cnt   (w_cnt),
        .i_wr_data  (w_wdata),
        .i_rd_en    (w_pop),
        .o_rd_valid (w_rd_valid),
        .o_rd_data  (w_rd_data),
        .o_count    (w_count)
    );

    // Dropped-for-space groups still consume seq numbers so the checker sees the gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq       <= '0;
            r_stall     <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_proto <= 1'b0;
        end else begin
            if (w_contig && !flush) begin
                r_seq <= r_seq + 64'(w_cnt);
            end
            if (w_ovf && !flush) begin
                r_err_ovf <= 1'b1;
            end
            if (!w_contig || w_opbad) begin
                r_err_proto <= 1'b1;
            end
            r_stall <= (w_occ_next >= DEPTH - 2 * NRET);
        end
    end

    assign ret_stall  = r_stall;
    assign err_ovf    = r_err_ovf;
    assign err_proto  = r_err_proto;
    assign occupancy  = w_count;
    assign out_valid  = w_rd_valid;
    assign out_ops    = w_rd_data[OPSW-1:0];
    assign out_op_num = w_rd_data[OPSW +: OPNW];
    assign out_ir     = w_rd_data[OPSW+OPNW +: 32];
    assign out_pc     = w_rd_data[OPSW+OPNW+32 +: XLEN];
    assign out_seq    = w_rd_data[RECW-64 +: 64];

endmodule

// File: tb/tb_cosim_retire_buffer.sv
// Bench for cosim_retire_buffer (NRET=2, XLEN=64, MAX_OP=4, DEPTH=16).
// Queue model of the buffer checked every cycle, plus directed literal checks.
module tb_cosim_retire_buffer;

    localparam int OPW  = 136;
    localparam int OPSW = 544;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [1:0]        ret_valid;
    logic [127:0]      ret_pc;
    logic [63:0]       ret_ir;
    logic [5:0]        ret_op_num;
    logic [2*OPSW-1:0] ret_ops;
    logic              ret_stall;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_seq;
    logic [63:0]       out_pc;
    logic [31:0]       out_ir;
    logic [2:0]        out_op_num;
    logic [OPSW-1:0]   out_ops;
    logic [4:0]        occupancy;
    logic              err_ovf;
    logic              err_proto;

    cosim_retire_buffer #(
        .NRET(2), .XLEN(64), .MAX_OP(4), .DEPTH(16)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_ir(ret_ir),
        .ret_op_num(ret_op_num), .ret_ops(ret_ops),
        .ret_stall(ret_stall), .out_valid(out_valid), .out_ready(out_ready),
        .out_seq(out_seq), .out_pc(out_pc), .out_ir(out_ir),
        .out_op_num(out_op_num), .out_ops(out_ops),
        .occupancy(occupancy), .err_ovf(err_ovf), .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit run   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [OPSW-1:0] act,
                         input logic [OPSW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic [63:0]     seq;
        logic [63:0]     pc;
        logic [31:0]     ir;
        logic [2:0]      num;
        logic [OPSW-1:0] ops;
    } rec_t;

    rec_t        q[$];
    rec_t        m_r;
    logic [63:0] m_seq;
    bit          m_ovf, m_proto, m_stall, m_pop, m_legal;
    int          m_cnt, m_free;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_seq   = 0;
            m_ovf   = 0;
            m_proto = 0;
            m_stall = 0;
        end else begin
            m_cnt   = int'(ret_valid[0]) + int'(ret_valid[1]);
            m_legal = (ret_valid != 2'b10);
            if (!m_legal) m_proto = 1;
            for (int l = 0; l < 2; l++)
                if (ret_valid[l] && ret_op_num[l*3 +: 3] > 3'd4) m_proto = 1;
            if (flush) begin
                q.delete();
            end else begin
                m_pop  = (q.size() > 0) && out_ready;
                m_free = 16 - q.size() + int'(m_pop);
                if (m_pop) void'(q.pop_front());
                if (m_legal) begin
                    if (m_cnt > m_free) begin
                        m_ovf = 1;
                    end else begin
                        for (int l = 0; l < m_cnt; l++) begin
                            m_r.seq = m_seq + 64'(l);
                            m_r.pc  = ret_pc[l*64 +: 64];
                            m_r.ir  = ret_ir[l*32 +: 32];
                            m_r.num = ret_op_num[l*3 +: 3];
                            if (m_r.num > 3'd4) m_r.num = 3'd4;
                            m_r.ops = ret_ops[l*OPSW +: OPSW];
                            for (int k = 0; k < 4; k++)
                                if (k >= int'(m_r.num)) m_r.ops[k*OPW +: OPW] = '0;
                            q.push_back(m_r);
                        end
                    end
                    m_seq = m_seq + 64'(m_cnt);
                end
            end
            m_stall = (q.size() >= 12);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (run && !rst) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("occupancy", 64'(occupancy), 64'(q.size()));
            chk("ret_stall", 64'(ret_stall), 64'(m_stall));
            chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
            chk("err_proto", 64'(err_proto), 64'(m_proto));
            if (q.size() > 0) begin
                chk("out_seq", out_seq, q[0].seq);
                chk("out_pc", out_pc, q[0].pc);
                chk("out_ir", 64'(out_ir), 64'(q[0].ir));
                chk("out_op_num", 64'(out_op_num), 64'(q[0].num));
                chk_w("out_ops", out_ops, q[0].ops);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [63:0] npc = 64'h2000;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_lanes(input logic [1:0] v,
                             input logic [63:0] pc0, input logic [2:0] n0,
                             input logic [63:0] pc1, input logic [2:0] n1);
        logic [63:0] p;
        ret_valid  = v;
        ret_pc     = {pc1, pc0};
        ret_ir     = {pc1[31:0] ^ 32'h13, pc0[31:0] ^ 32'h13};
        ret_op_num = {n1, n0};
        for (int l = 0; l < 2; l++) begin
            p = (l == 0) ? pc0 : pc1;
            for (int k = 0; k < 4; k++)
                ret_ops[(l*4+k)*OPW +: OPW] =
                    {8'(l*4+k+1), p + 64'(k*8), ~p ^ 64'(k)};
        end
    endtask

    task automatic push2();
        set_lanes(2'b11, npc, 3'd3, npc + 64'd4, 3'd4);
        npc = npc + 64'd8;
    endtask

    task automatic push1();
        set_lanes(2'b01, npc, 3'd2, 64'h0, 3'd0);
        npc = npc + 64'd4;
    endtask

    task automatic idle();
        ret_valid = 2'b00;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        ret_valid = '0; ret_pc = '0; ret_ir = '0;
        ret_op_num = '0; ret_ops = '0;
        repeat (2) cyc();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_seq", out_seq, 64'd0);
        chk("rst_stall", 64'(ret_stall), 64'd0);
        rst = 1'b0;
        run = 1'b1;
        cyc();

        // 1: two-lane retire
        set_lanes(2'b11, 64'h1000, 3'd1, 64'h1004, 3'd2);
        chk("t1_pre_valid", 64'(out_valid), 64'd0);
        cyc();
        idle();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_seq0", out_seq, 64'd0);
        chk("t1_pc0", out_pc, 64'h1000);
        chk("t1_num0", 64'(out_op_num), 64'd1);
        out_ready = 1'b1;
        cyc();
        chk("t1_seq1", out_seq, 64'd1);
        chk("t1_pc1", out_pc, 64'h1004);
        chk("t1_num1", 64'(out_op_num), 64'd2);
        cyc();
        out_ready = 1'b0;
        chk("t1_empty", 64'(out_valid), 64'd0);

        // 2: fill until stall, then overflow at 15
        for (int i = 0; i < 20 && !ret_stall; i++) begin
            push2();
            cyc();
        end
        idle();
        chk("t2_stall_occ", 64'(occupancy), 64'd12);
        chk("t2_stall", 64'(ret_stall), 64'd1);
        push2(); cyc();
        push1(); cyc();
        push2(); cyc();
        idle();
        chk("t2_ovf", 64'(err_ovf), 64'd1);
        chk("t2_occ15", 64'(occupancy), 64'd15);
        push1(); cyc();
        idle();
        chk("t2_occ16", 64'(occupancy), 64'd16);

        // 3: full, push 2 with pop 1 -> dropped
        push2();
        out_ready = 1'b1;
        cyc();
        idle();
        out_ready = 1'b0;
        chk("t3_occ", 64'(occupancy), 64'd15);
        out_ready = 1'b1;
        repeat (14) cyc();
        chk("t2_seq_gap", out_seq, 64'd19);
        cyc();
        out_ready = 1'b0;
        chk("t3_drained", 64'(out_valid), 64'd0);

        // 4: protocol violations
        chk("t4_proto0", 64'(err_proto), 64'd0);
        set_lanes(2'b10, 64'h3100, 3'd1, 64'h3104, 3'd1);
        cyc();
        idle();
        chk("t4_proto1", 64'(err_proto), 64'd1);
        chk("t4_occ", 64'(occupancy), 64'd0);
        set_lanes(2'b01, 64'h3000, 3'd7, 64'h0, 3'd0);
        cyc();
        idle();
        chk("t4_seq", out_seq, 64'd22);
        chk("t4_clamp", 64'(out_op_num), 64'd4);
        chk("t4_pc", out_pc, 64'h3000);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // 5: flush beats push and pop
        push2(); cyc();
        push2(); cyc();
        push1(); cyc();
        chk("t5_occ5", 64'(occupancy), 64'd5);
        push2();
        flush = 1'b1;
        out_ready = 1'b1;
        cyc();
        flush = 1'b0;
        out_ready = 1'b0;
        idle();
        chk("t5_occ0", 64'(occupancy), 64'd0);
        chk("t5_valid", 64'(out_valid), 64'd0);
        push1(); cyc();
        idle();
        chk("t5_seq", out_seq, 64'd28);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // 6: reset mid-burst
        repeat (4) begin
            push2(); cyc();
        end
        push1(); cyc();
        chk("t6_occ9", 64'(occupancy), 64'd9);
        push2();
        out_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_occ", 64'(occupancy), 64'd0);
        chk("t6_seq", out_seq, 64'd0);
        chk("t6_pc", out_pc, 64'd0);
        chk("t6_num", 64'(out_op_num), 64'd0);
        chk("t6_stall", 64'(ret_stall), 64'd0);
        chk("t6_ovf", 64'(err_ovf), 64'd0);
        chk("t6_proto", 64'(err_proto), 64'd0);
        cyc();
        rst = 1'b0;
        idle();
        out_ready = 1'b0;
        cyc();
        cyc();
        chk("t6_no_stale", 64'(out_valid), 64'd0);
        push1(); cyc();
        idle();
        chk("t6_seq_restart", out_seq, 64'd0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
